// File: rtl/ps2_pkg.sv
// Shared PS2 types and helpers for the transceiver and its testbench.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DATA,
    R_PARITY,
    R_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_WAIT,
    T_INHIBIT,
    T_REQ,
    T_DATA,
    T_PARITY,
    T_STOP,
    T_ACK
  } tx_state_t;

  // Parity bit that makes the 9-bit XOR equal 1.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head, sticky overflow and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot, so a full FIFO still accepts a simultaneous push.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_transceiver.sv
// PS2 host transceiver: device-to-host receiver with FIFO and host-to-device command transmitter.
module ps2_transceiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_dat_i,
  output logic                          ps2_clk_oe,
  output logic                          ps2_dat_oe,
  input  logic                          send,
  input  logic [7:0]                    command,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          tx_err,
  output logic                          rx_valid,
  output logic [7:0]                    rx_data,
  input  logic                          rx_ready,
  output logic                          rx_err,
  output logic                          rx_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev, ps2_fall, ps2_dat;
  rx_state_t              rx_state;
  tx_state_t              tx_state;
  logic [2:0]             rx_cnt;
  logic [7:0]             rx_shift;
  logic                   rx_par, rx_push, fifo_empty;
  logic [3:0]             tx_cnt;
  logic [7:0]             tx_byte;
  logic [INH_W-1:0]       inh_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic                   tx_active, tx_timed, rx_timed, timeout;

  // Input synchronisers and falling-edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign ps2_fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign ps2_dat   = dat_sync[SYNC_STAGES-1];
  assign tx_active = (tx_state != T_IDLE) && (tx_state != T_WAIT);
  assign tx_timed  = tx_active && (tx_state != T_INHIBIT);
  assign rx_timed  = (rx_state != R_IDLE);
  assign timeout   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !ps2_fall;

  // Inter-edge watchdog, shared because receiver and transmitter never run together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  to_cnt <= '0;
    else if (ps2_fall || !(rx_timed || tx_timed)) to_cnt <= '0;
    else                                       to_cnt <= to_cnt + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rx_state == R_DATA && ps2_fall)   rx_shift <= {ps2_dat, rx_shift[7:1]};
    if (rx_state == R_PARITY && ps2_fall) rx_par   <= ps2_dat;
    if (tx_state == T_IDLE && send)       tx_byte  <= command;
  end

  // Receive state machine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_push  <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      rx_err  <= 1'b0;
      if (tx_active) begin
        rx_state <= R_IDLE;
      end else if (rx_timed && timeout) begin
        rx_state <= R_IDLE;
        rx_err   <= 1'b1;
      end else if (ps2_fall) begin
        case (rx_state)
          R_IDLE: if (!ps2_dat) begin
            rx_state <= R_DATA;
            rx_cnt   <= '0;
          end
          R_DATA: begin
            rx_cnt <= rx_cnt + 3'd1;
            if (rx_cnt == 3'd7) rx_state <= R_PARITY;
          end
          R_PARITY: rx_state <= R_STOP;
          R_STOP: begin
            rx_state <= R_IDLE;
            if ((^{rx_shift, rx_par}) && ps2_dat) rx_push <= 1'b1;
            else                                  rx_err  <= 1'b1;
          end
          default: rx_state <= R_IDLE;
        endcase
      end
    end
  end

  // Transmit state machine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state   <= T_IDLE;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      tx_cnt     <= '0;
      inh_cnt    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (tx_timed && timeout) begin
        tx_state   <= T_IDLE;
        tx_busy    <= 1'b0;
        tx_err     <= 1'b1;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
      end else begin
        case (tx_state)
          T_IDLE: if (send) begin
            tx_busy  <= 1'b1;
            tx_state <= T_WAIT;
          end
          T_WAIT: if (rx_state == R_IDLE) begin
            tx_state   <= T_INHIBIT;
            inh_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
          end
          T_INHIBIT: begin
            inh_cnt <= inh_cnt + INH_W'(1);
            if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
              tx_state   <= T_REQ;
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b1;
            end
          end
          T_REQ: if (ps2_fall) begin
            ps2_dat_oe <= ~tx_byte[0];
            tx_cnt     <= 4'd1;
            tx_state   <= T_DATA;
          end
          T_DATA: if (ps2_fall) begin
            if (tx_cnt == 4'd8) begin
              ps2_dat_oe <= ~odd_parity(tx_byte);
              tx_state   <= T_PARITY;
            end else begin
              ps2_dat_oe <= ~tx_byte[tx_cnt[2:0]];
              tx_cnt     <= tx_cnt + 4'd1;
            end
          end
          T_PARITY: if (ps2_fall) begin
            ps2_dat_oe <= 1'b0;
            tx_state   <= T_STOP;
          end
          // Stop bit is the released line; the ACK arrives on the following edge.
          T_STOP: tx_state <= T_ACK;
          T_ACK: if (ps2_fall) begin
            tx_state <= T_IDLE;
            tx_busy  <= 1'b0;
            if (!ps2_dat) tx_done <= 1'b1;
            else          tx_err  <= 1'b1;
          end
          default: tx_state <= T_IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_ready),
    .head      (rx_data),
    .empty     (fifo_empty),
    .overflow  (rx_overflow),
    .count     (rx_count)
  );

  assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_ps2_transceiver.sv
// Directed bench for ps2_transceiver with an open-drain PS2 device model.
module tb_ps2_transceiver;

  localparam int DEPTH = 4;
  localparam int INH   = 100;
  localparam int TO    = 400;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
  logic       send = 1'b0;
  logic [7:0] command = 8'h00;
  logic       tx_busy, tx_done, tx_err, rx_valid, rx_ready, rx_err, rx_overflow;
  logic [7:0] rx_data;
  logic [2:0] rx_count;

  int checks = 0;
  int failures = 0;
  int rx_err_cnt = 0;
  int tx_done_cnt = 0;
  int tx_err_cnt = 0;
  int busy_overlap = 0;

  assign ps2_clk_i = ~ps2_clk_oe & dev_clk;
  assign ps2_dat_i = ~ps2_dat_oe & dev_dat;

  always #5 clk = ~clk;

  ps2_transceiver #(
    .FIFO_DEPTH     (DEPTH),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_dat_i   (ps2_dat_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_dat_oe  (ps2_dat_oe),
    .send        (send),
    .command     (command),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rx_err      (rx_err),
    .rx_overflow (rx_overflow),
    .rx_count    (rx_count)
  );

  always @(negedge clk) begin
    if (rx_err)            rx_err_cnt   <= rx_err_cnt + 1;
    if (tx_done)           tx_done_cnt  <= tx_done_cnt + 1;
    if (tx_err)            tx_err_cnt   <= tx_err_cnt + 1;
    if ((tx_done || tx_err) && tx_busy) busy_overlap <= busy_overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Device clocks out the first n bits of an 11-bit frame, LSB (start) first.
  task automatic dev_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      dev_dat = f[i];
      cyc(HALF);
      dev_clk = 1'b0;
      cyc(HALF);
      dev_clk = 1'b1;
    end
  endtask

  task automatic dev_frame(input logic [7:0] b, input logic par, input logic stp);
    dev_bits({stp, par, b, 1'b0}, 11);
    dev_dat = 1'b1;
    cyc(HALF);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, rx_data, exp);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    int n;
    int e0, d0, t0;
    logic [8:0] tx_bits;
    rx_ready = 1'b0;

    // Reset state
    cyc(3);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_overflow", rx_overflow, 0);
    check("rst_pulses", {tx_done, tx_err, rx_err}, 0);
    rst = 1'b1;
    cyc(5);

    // Good frame 0x1C, parity 0
    e0 = rx_err_cnt;
    dev_frame(8'h1C, 1'b0, 1'b1);
    check("rx_good_count", rx_count, 1);
    check("rx_good_valid", rx_valid, 1);
    check("rx_good_err", rx_err_cnt - e0, 0);
    pop_check("rx_good_data", 8'h1C);
    check("rx_pop_count", rx_count, 0);

    // Bad parity 0x1C, parity 1
    e0 = rx_err_cnt;
    dev_frame(8'h1C, 1'b1, 1'b1);
    check("rx_badpar_err", rx_err_cnt - e0, 1);
    check("rx_badpar_count", rx_count, 0);

    // Bad stop bit
    e0 = rx_err_cnt;
    dev_frame(8'h1C, 1'b0, 1'b0);
    check("rx_badstop_err", rx_err_cnt - e0, 1);
    check("rx_badstop_count", rx_count, 0);

    // Overflow: five good frames into a 4-deep FIFO
    dev_frame(8'h1C, 1'b0, 1'b1);
    dev_frame(8'h2A, 1'b0, 1'b1);
    dev_frame(8'h55, 1'b1, 1'b1);
    dev_frame(8'hF0, 1'b1, 1'b1);
    check("ovf_before", rx_overflow, 0);
    dev_frame(8'h01, 1'b0, 1'b1);
    check("ovf_count", rx_count, 4);
    check("ovf_flag", rx_overflow, 1);
    pop_check("ovf_head0", 8'h1C);
    pop_check("ovf_head1", 8'h2A);
    pop_check("ovf_head2", 8'h55);
    pop_check("ovf_head3", 8'hF0);
    check("ovf_empty", rx_valid, 0);
    check("ovf_sticky", rx_overflow, 1);

    // Transmit 0xED with ACK
    d0 = tx_done_cnt;
    t0 = tx_err_cnt;
    tx_bits = 9'b1_1110_1101;
    command = 8'hED;
    send = 1'b1;
    cyc(1);
    send = 1'b0;
    command = 8'h00;
    check("tx_busy_set", tx_busy, 1);
    n = 0;
    while (!ps2_clk_oe && n < 50) begin cyc(1); n++; end
    check("tx_inhibit_start", ps2_clk_oe, 1);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin cyc(1); n++; end
    check("tx_inhibit_len", n, INH);
    check("tx_req_dat", ps2_dat_oe, 1);
    cyc(HALF);
    for (int k = 0; k < 11; k++) begin
      if (k == 10) dev_dat = 1'b0;
      cyc(HALF);
      dev_clk = 1'b0;
      cyc(HALF);
      if (k < 9) check($sformatf("tx_bit%0d", k), ps2_dat_i, tx_bits[k]);
      if (k == 9) check("tx_stop_release", ps2_dat_oe, 0);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    cyc(HALF);
    check("tx_done_pulse", tx_done_cnt - d0, 1);
    check("tx_no_err", tx_err_cnt - t0, 0);
    check("tx_busy_clear", tx_busy, 0);

    // Busy gating: second send while busy is ignored; device stalls after bit 2
    d0 = tx_done_cnt;
    t0 = tx_err_cnt;
    command = 8'hED;
    send = 1'b1;
    cyc(1);
    send = 1'b0;
    n = 0;
    while (!ps2_clk_oe && n < 50) begin cyc(1); n++; end
    send = 1'b1;
    cyc(1);
    send = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 1000) begin cyc(1); n++; end
    cyc(HALF);
    for (int k = 0; k < 3; k++) begin
      cyc(HALF);
      dev_clk = 1'b0;
      cyc(HALF);
      dev_clk = 1'b1;
    end
    check("tmo_busy_mid", tx_busy, 1);
    cyc(TO + 2 * HALF);
    check("tmo_err_pulse", tx_err_cnt - t0, 1);
    check("tmo_no_done", tx_done_cnt - d0, 0);
    check("tmo_clk_oe", ps2_clk_oe, 0);
    check("tmo_dat_oe", ps2_dat_oe, 0);
    check("tmo_busy", tx_busy, 0);
    cyc(INH + 50);
    check("tmo_send_ignored", {tx_busy, ps2_clk_oe}, 0);
    check("busy_overlap", busy_overlap, 0);

    // Reset during bit 5 of a receive
    e0 = rx_err_cnt;
    d0 = tx_done_cnt;
    t0 = tx_err_cnt;
    dev_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6);
    dev_dat = 1'b1;
    cyc(HALF);
    dev_clk = 1'b0;
    cyc(5);
    rst = 1'b0;
    cyc(HALF);
    dev_clk = 1'b1;
    cyc(3);
    check("mid_rst_count", rx_count, 0);
    check("mid_rst_ovf", rx_overflow, 0);
    check("mid_rst_valid", rx_valid, 0);
    rst = 1'b1;
    cyc(2 * TO);
    check("mid_rst_no_rxerr", rx_err_cnt - e0, 0);
    check("mid_rst_no_tx", (tx_done_cnt - d0) + (tx_err_cnt - t0), 0);
    dev_frame(8'h1C, 1'b0, 1'b1);
    check("post_rst_count", rx_count, 1);
    check("post_rst_data", rx_data, 8'h1C);
    check("post_rst_err", rx_err_cnt - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_transceiver.md
PS2_TRANSCEIVER -- requirements
Module: ps2_transceiver

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the receive FIFO depth in bytes (power of two, 2 or more).
REQ-002 The block SHALL have parameter INHIBIT_CYCLES, default 5000, meaning the number of clk cycles the host holds PS2 clock low before transmitting (at least 100 us).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum number of clk cycles allowed between PS2 clock falling edges inside a frame.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth on each PS2 input.
REQ-005 The block SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  system clock; all logic runs on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- ps2_clk_i  in  1  PS2 clock line, read back from the pad.
- ps2_dat_i  in  1  PS2 data line, read back from the pad.
- ps2_clk_oe  out  1  drive PS2 clock low when 1; released when 0.
- ps2_dat_oe  out  1  drive PS2 data low when 1; released when 0.
- send  in  1  one-cycle request to transmit command.
- command  in  8  byte to transmit.
- tx_busy  out  1  a transmission is pending or in progress.
- tx_done  out  1  one-cycle pulse: device acknowledged the byte.
- tx_err  out  1  one-cycle pulse: transmission aborted (timeout or missing ACK).
- rx_valid  out  1  the FIFO is not empty.
- rx_data  out  8  the byte at the FIFO head.
- rx_ready  in  1  pop the FIFO head when rx_valid is 1.
- rx_err  out  1  one-cycle pulse: received frame discarded (parity, start, stop or timeout).
- rx_overflow  out  1  sticky; set when a good byte is dropped because the FIFO is full.
- rx_count  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries.

Function
REQ-006 ps2_clk_i and ps2_dat_i SHALL each pass through SYNC_STAGES flip-flops; a falling edge is the synchronised clock going from 1 to 0, detected with one cycle of latency.
REQ-007 The receive state machine SHALL use states R_IDLE, R_DATA, R_PARITY and R_STOP.
- In R_IDLE, a falling edge with data 0 moves to R_DATA.
- In R_DATA, 8 falling edges sample the bits LSB first, then the machine moves to R_PARITY.
- R_PARITY samples the parity bit and moves to R_STOP.
- R_STOP samples the stop bit and returns to R_IDLE.
REQ-008 Parity SHALL be odd: the XOR of the 8 data bits and the parity bit must equal 1.
REQ-009 A frame with correct parity and stop bit 1 SHALL be pushed into the FIFO in the cycle after the stop-bit edge; otherwise rx_err pulses and nothing is pushed.
REQ-010 A timeout (TIMEOUT_CYCLES with no falling edge while the receiver is not in R_IDLE) SHALL return the receiver to R_IDLE and pulse rx_err.
REQ-011 The FIFO SHALL pop on rx_valid and rx_ready together; rx_data SHALL show the head combinationally from FIFO storage.
REQ-012 A push and a pop in the same cycle SHALL leave rx_count unchanged, including when the FIFO is full.
REQ-013 A push into a full FIFO without a pop SHALL drop the byte and set rx_overflow, which stays set until reset.
REQ-014 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 The transmitter SHALL capture command on send only when tx_busy is 0; a send while tx_busy is 1 SHALL be ignored.
REQ-016 The transmit state machine SHALL use states T_IDLE, T_WAIT, T_INHIBIT, T_REQ, T_DATA, T_PARITY, T_STOP and T_ACK.
- T_IDLE: on an accepted send, tx_busy is set and the machine moves to T_WAIT.
- T_WAIT: holds until the receiver is in R_IDLE.
- T_INHIBIT: ps2_clk_oe is 1 for INHIBIT_CYCLES cycles.
- T_REQ: ps2_dat_oe is 1 and ps2_clk_oe is 0.
- T_DATA: data bits are placed LSB first, each updated on a falling edge (ps2_dat_oe = NOT bit).
- T_PARITY: the odd parity bit is placed.
- T_STOP: ps2_dat_oe is released.
- T_ACK: on the next falling edge, data 0 gives tx_done; data 1 gives tx_err.
REQ-017 While the transmitter is in any state from T_INHIBIT through T_ACK, the receiver SHALL stay in R_IDLE and ignore the lines.
REQ-018 A timeout in any transmit state after T_INHIBIT SHALL release both outputs, pulse tx_err and return the transmitter to T_IDLE.
REQ-019 tx_busy SHALL clear in the same cycle that tx_done or tx_err pulses.

Reset
REQ-020 While rst is 0, the following SHALL hold:
- both state machines are idle;
- the FIFO is empty, rx_count is 0 and rx_overflow is 0;
- ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_err, rx_valid and rx_err are all 0;
- rx_data is 0 and the synchronisers are preset to 1.
REQ-021 A reset asserted mid-frame SHALL abandon the frame; no done or error pulse is issued after rst is released.

Structure
REQ-022 A shared package ps2_pkg SHALL hold the receive and transmit state enums and the constant PS2_FRAME_BITS = 11.
REQ-023 The FIFO SHALL be the separate sub-module sync_fifo, parametrised by WIDTH and DEPTH.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Device sends 0x1C with parity 0 -> one push; rx_data = 0x1C; rx_err stays 0.
- Device sends 0x1C with parity 1 -> rx_err pulses once; rx_count stays 0.
- With FIFO_DEPTH = 4 and rx_ready = 0, 5 good frames -> rx_count = 4, rx_overflow = 1, and the head is still the first byte.
- send with command = 0xED and the device ACKs -> ps2_clk_oe is low for INHIBIT_CYCLES; the bits 1,0,1,1,0,1,1,1 then parity 1 are driven; tx_done pulses; tx_busy = 0.
- The device stops clocking after the 3rd data bit -> after TIMEOUT_CYCLES, tx_err pulses and both oe outputs are 0.
- rst is driven to 0 during bit 5 of a receive -> rx_count = 0, no pulses, and the next full frame is received correctly.
